// File: rtl/debug_sender_pkg.sv
// Shared state encoding, idle level and counter sizing helper for the serial debug sender.
package debug_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } sender_state_e;

  localparam logic IDLE_LEVEL = 1'b0;

  // Bits needed to count n distinct values, never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_sync_fifo.sv
// Single-clock word FIFO with flush; the caller guarantees no push when full and no pop when empty.
module debug_sync_fifo
  import debug_sender_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LW-1:0]    level
);

  localparam int PW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;

  assign head_data = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy; a flush only rewinds pointers and level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level    <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/debug_serial_sender.sv
// Buffered serial debug transmitter: FIFO-fed shift register, DIV clocks per bit, GAP idle bit-periods per frame.
module debug_serial_sender
  import debug_sender_pkg::*;
#(
  parameter int WIDTH     = 40,
  parameter int DEPTH     = 4,
  parameter int DIV       = 4,
  parameter int GAP       = 5,
  parameter bit MSB_FIRST = 1'b1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             frame_start,
  output logic             busy,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  localparam int DW      = cnt_width(DIV);
  localparam int BW      = cnt_width(WIDTH);
  localparam int GAP_CYC = GAP * DIV;
  localparam int GW      = cnt_width(GAP_CYC);

  sender_state_e    state_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] next_shift_s;
  logic [DW-1:0]    div_cnt_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [GW-1:0]    gap_cnt_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic tx_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Room is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign in_ready     = (level != LW'(DEPTH));
  assign push_s       = in_valid && in_ready && !clear;
  assign pop_s        = (state_r == ST_IDLE) && (level != '0) && !clear;
  assign next_shift_s = MSB_FIRST ? (shift_r << 1) : (shift_r >> 1);

  debug_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (push_s),
    .push_data(in_data),
    .pop      (pop_s),
    .head_data(head_s),
    .level    (level)
  );

  // Sticky drop flag, cleared only by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow <= 1'b1;
    end
  end

  // Frame sequencer: load from FIFO, shift WIDTH bits at DIV clocks each, then hold the idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      sout        <= IDLE_LEVEL;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (clear) begin
      state_r     <= ST_IDLE;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      sout        <= IDLE_LEVEL;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level != '0) begin
            shift_r     <= head_s;
            div_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            sout        <= tx_bit(head_s);
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state_r     <= ST_SHIFT;
          end else begin
            sout        <= IDLE_LEVEL;
            frame_start <= 1'b0;
            busy        <= 1'b0;
          end
        end
        ST_SHIFT: begin
          frame_start <= 1'b0;
          if (div_cnt_r == DW'(DIV - 1)) begin
            div_cnt_r <= '0;
            if (bit_cnt_r == BW'(WIDTH - 1)) begin
              sout      <= IDLE_LEVEL;
              gap_cnt_r <= '0;
              if (GAP == 0) begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end else begin
                state_r <= ST_GAP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
              shift_r   <= next_shift_s;
              sout      <= tx_bit(next_shift_s);
            end
          end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
          end
        end
        ST_GAP: begin
          sout        <= IDLE_LEVEL;
          frame_start <= 1'b0;
          if (gap_cnt_r == GW'(GAP_CYC - 1)) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          sout        <= IDLE_LEVEL;
          frame_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_serial_sender.sv
// Scoreboard bench: a default-parameter sender and a narrow LSB-first sender, frames rebuilt from sout by monitors.
`timescale 1ns/1ps
module tb_debug_serial_sender;

  localparam int W      = 40;
  localparam int DIV    = 4;
  localparam int GAP    = 5;
  localparam int D_BITS = W * DIV;
  localparam int D_TOT  = (W + GAP) * DIV;
  localparam int D_PER  = 1 + D_TOT;
  localparam int SW     = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          d_valid = 1'b0;
  logic [W-1:0]  d_data = '0;
  logic          d_ready, d_sout, d_fs, d_busy, d_ovf;
  logic [2:0]    d_level;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          s_ready, s_sout, s_fs, s_busy, s_ovf;
  logic [2:0]    s_level;

  debug_serial_sender dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(d_valid), .in_data(d_data),
    .in_ready(d_ready), .sout(d_sout), .frame_start(d_fs), .busy(d_busy),
    .level(d_level), .overflow(d_ovf)
  );

  debug_serial_sender #(.WIDTH(SW), .DEPTH(4), .DIV(1), .GAP(0), .MSB_FIRST(1'b0)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .sout(s_sout), .frame_start(s_fs), .busy(s_busy),
    .level(s_level), .overflow(s_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    bit           ok;
    int           t;
  } frame_t;

  frame_t        rx_q[$];
  frame_t        srx_q[$];
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] sexp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int fs_count = 0;
  int last_fs_t = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Default-instance monitor: rebuilds MSB-first words, checks bit hold, gap level, frame_start and busy shape.
  initial begin
    int m_cnt;
    bit m_ok;
    int m_t;
    logic [W-1:0] m_word;
    m_cnt = -1; m_ok = 1'b0; m_t = 0; m_word = '0;
    forever begin
      @(negedge clk);
      if (d_fs === 1'b1) begin fs_count++; last_fs_t = cyc; end
      if (m_cnt < 0 && d_fs === 1'b1) begin m_cnt = 0; m_ok = 1'b1; m_t = cyc; m_word = '0; end
      if (m_cnt >= 0) begin
        if (m_cnt < D_TOT && d_busy !== 1'b1) begin
          m_cnt = -1;
        end else if (m_cnt < D_BITS) begin
          if (m_cnt % DIV == 0) m_word = {m_word[W-2:0], d_sout};
          else if (d_sout !== m_word[0]) m_ok = 1'b0;
          if ((m_cnt == 0) != (d_fs === 1'b1)) m_ok = 1'b0;
          m_cnt++;
        end else if (m_cnt < D_TOT) begin
          if (d_sout !== 1'b0 || d_fs !== 1'b0) m_ok = 1'b0;
          m_cnt++;
        end else begin
          if (d_busy !== 1'b0 || d_sout !== 1'b0) m_ok = 1'b0;
          rx_q.push_back('{m_word, m_ok, m_t});
          m_cnt = -1;
        end
      end
    end
  end

  // Narrow-instance monitor: one clock per bit, LSB first, no gap.
  initial begin
    int sm_cnt;
    bit sm_ok;
    int sm_t;
    logic [SW-1:0] sm_word;
    sm_cnt = -1; sm_ok = 1'b0; sm_t = 0; sm_word = '0;
    forever begin
      @(negedge clk);
      if (sm_cnt < 0 && s_fs === 1'b1) begin sm_cnt = 0; sm_ok = 1'b1; sm_t = cyc; sm_word = '0; end
      if (sm_cnt >= 0) begin
        if (sm_cnt < SW && s_busy !== 1'b1) begin
          sm_cnt = -1;
        end else if (sm_cnt < SW) begin
          sm_word[sm_cnt] = s_sout;
          if ((sm_cnt == 0) != (s_fs === 1'b1)) sm_ok = 1'b0;
          sm_cnt++;
        end else begin
          if (s_busy !== 1'b0 || s_sout !== 1'b0) sm_ok = 1'b0;
          srx_q.push_back('{{32'h0, sm_word}, sm_ok, sm_t});
          sm_cnt = -1;
        end
      end
    end
  end

  task automatic wait_rx(input int n, input int lim, output bit got);
    int k = 0;
    while (rx_q.size() < n && k < lim) begin @(negedge clk); k++; end
    got = (rx_q.size() >= n);
  endtask

  task automatic wait_srx(input int n, input int lim, output bit got);
    int k = 0;
    while (srx_q.size() < n && k < lim) begin @(negedge clk); k++; end
    got = (srx_q.size() >= n);
  endtask

  task automatic wait_fs(input int fs0, output bit got);
    int k = 0;
    while (fs_count == fs0 && k < 10) begin @(negedge clk); k++; end
    got = (fs_count != fs0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (d_sout !== 1'b0) $display("FAIL rst_sout got %b want 0", d_sout); else n_pass++;
    n_total++; if (d_fs !== 1'b0) $display("FAIL rst_frame_start got %b want 0", d_fs); else n_pass++;
    n_total++; if (d_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", d_busy); else n_pass++;
    n_total++; if (d_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", d_ready); else n_pass++;
    n_total++; if (d_level !== 3'd0) $display("FAIL rst_level got %0d want 0", d_level); else n_pass++;
    n_total++; if (d_ovf !== 1'b0) $display("FAIL rst_overflow got %b want 0", d_ovf); else n_pass++;
    n_total++; if (s_busy !== 1'b0 || s_sout !== 1'b0) $display("FAIL rst_small busy=%b sout=%b want 0/0", s_busy, s_sout); else n_pass++;
  endtask

  task automatic test_single_frame;
    int t_wr, fs0;
    bit got;
    frame_t f;
    logic [W-1:0] e;
    fs0 = fs_count;
    t_wr = cyc;
    d_valid = 1'b1; d_data = 40'hA999999991; exp_q.push_back(40'hA999999991);
    @(negedge clk);
    d_valid = 1'b0;
    wait_rx(1, 400, got);
    n_total++; if (!got) $display("FAIL single_timeout got 0 frames want 1"); else n_pass++;
    if (got) begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (f.data !== e) $display("FAIL single_data got %h want %h", f.data, e); else n_pass++;
      n_total++; if (!f.ok) $display("FAIL single_shape got bad timing want clean frame"); else n_pass++;
      n_total++; if (f.t != t_wr + 2) $display("FAIL single_latency got %0d want %0d", f.t, t_wr + 2); else n_pass++;
      n_total++; if (fs_count - fs0 != 1) $display("FAIL single_fs_count got %0d want 1", fs_count - fs0); else n_pass++;
    end
  endtask

  task automatic test_lsb_small;
    bit got;
    frame_t f0, f1;
    logic [SW-1:0] e0, e1;
    s_valid = 1'b1; s_data = 8'h01; sexp_q.push_back(8'h01);
    @(negedge clk);
    s_data = 8'h80; sexp_q.push_back(8'h80);
    @(negedge clk);
    s_valid = 1'b0;
    wait_srx(2, 60, got);
    n_total++; if (!got) $display("FAIL lsb_timeout got %0d frames want 2", srx_q.size()); else n_pass++;
    if (got) begin
      f0 = srx_q.pop_front(); f1 = srx_q.pop_front();
      e0 = sexp_q.pop_front(); e1 = sexp_q.pop_front();
      n_total++; if (f0.data[SW-1:0] !== e0) $display("FAIL lsb_data0 got %h want %h", f0.data[SW-1:0], e0); else n_pass++;
      n_total++; if (f1.data[SW-1:0] !== e1) $display("FAIL lsb_data1 got %h want %h", f1.data[SW-1:0], e1); else n_pass++;
      n_total++; if (!f0.ok || !f1.ok) $display("FAIL lsb_shape got ok=%b%b want 11", f0.ok, f1.ok); else n_pass++;
      n_total++; if (f1.t - f0.t != 9) $display("FAIL lsb_spacing got %0d want 9", f1.t - f0.t); else n_pass++;
    end
  endtask

  task automatic test_push_pop;
    bit got;
    frame_t f0, f1;
    logic [W-1:0] e0, e1;
    d_valid = 1'b1; d_data = 40'h123456789A; exp_q.push_back(40'h123456789A);
    @(negedge clk);
    d_data = 40'hFEDCBA9876; exp_q.push_back(40'hFEDCBA9876);
    @(negedge clk);
    d_valid = 1'b0;
    n_total++; if (d_level !== 3'd1) $display("FAIL pushpop_level got %0d want 1", d_level); else n_pass++;
    wait_rx(2, 600, got);
    n_total++; if (!got) $display("FAIL pushpop_timeout got %0d frames want 2", rx_q.size()); else n_pass++;
    if (got) begin
      f0 = rx_q.pop_front(); f1 = rx_q.pop_front();
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      n_total++; if (f0.data !== e0 || f1.data !== e1) $display("FAIL pushpop_data got %h,%h want %h,%h", f0.data, f1.data, e0, e1); else n_pass++;
      n_total++; if (!f0.ok || !f1.ok) $display("FAIL pushpop_shape got ok=%b%b want 11", f0.ok, f1.ok); else n_pass++;
      n_total++; if (f1.t - f0.t != D_PER) $display("FAIL pushpop_spacing got %0d want %0d", f1.t - f0.t, D_PER); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    bit got;
    frame_t f;
    logic [W-1:0] e;
    logic [W-1:0] w;
    int prev_t;
    n_total++; if (d_ovf !== 1'b0) $display("FAIL ovf_pre got %b want 0", d_ovf); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      w = {8'(i + 1), 32'($urandom)};
      d_valid = 1'b1; d_data = w;
      if (i < 5) exp_q.push_back(w);
      @(negedge clk);
    end
    d_valid = 1'b0;
    n_total++; if (d_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", d_ovf); else n_pass++;
    n_total++; if (d_ready !== 1'b0) $display("FAIL ovf_in_ready got %b want 0", d_ready); else n_pass++;
    n_total++; if (d_level !== 3'd4) $display("FAIL ovf_level got %0d want 4", d_level); else n_pass++;
    wait_rx(5, 1200, got);
    n_total++; if (!got) $display("FAIL ovf_timeout got %0d frames want 5", rx_q.size()); else n_pass++;
    prev_t = 0;
    for (int i = 0; i < 5 && got; i++) begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (f.data !== e || !f.ok) $display("FAIL ovf_frame%0d got %h ok=%b want %h ok=1", i, f.data, f.ok, e); else n_pass++;
      if (i > 0) begin
        n_total++; if (f.t - prev_t != D_PER) $display("FAIL ovf_spacing%0d got %0d want %0d", i, f.t - prev_t, D_PER); else n_pass++;
      end
      prev_t = f.t;
    end
    n_total++; if (rx_q.size() != 0) $display("FAIL ovf_extra got %0d frames want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_clear;
    bit got;
    int fs0, fs1;
    fs0 = fs_count;
    d_valid = 1'b1; d_data = 40'hFFFFFFFFFF;
    @(negedge clk);
    d_data = 40'h1111111111;
    @(negedge clk);
    d_data = 40'h2222222222;
    @(negedge clk);
    d_valid = 1'b0;
    wait_fs(fs0, got);
    n_total++; if (!got) $display("FAIL clr_start got no frame_start want one"); else n_pass++;
    while (got && cyc < last_fs_t + 40) @(negedge clk);
    n_total++; if (d_level !== 3'd2 || d_sout !== 1'b1) $display("FAIL clr_pre level=%0d sout=%b want 2/1", d_level, d_sout); else n_pass++;
    clear = 1'b1; d_valid = 1'b1; d_data = 40'h3333333333;
    @(negedge clk);
    clear = 1'b0; d_valid = 1'b0;
    n_total++; if (d_sout !== 1'b0) $display("FAIL clr_sout got %b want 0", d_sout); else n_pass++;
    n_total++; if (d_busy !== 1'b0) $display("FAIL clr_busy got %b want 0", d_busy); else n_pass++;
    n_total++; if (d_level !== 3'd0) $display("FAIL clr_level got %0d want 0", d_level); else n_pass++;
    n_total++; if (d_ovf !== 1'b0) $display("FAIL clr_overflow got %b want 0", d_ovf); else n_pass++;
    fs1 = fs_count;
    repeat (300) @(negedge clk);
    n_total++; if (fs_count != fs1) $display("FAIL clr_no_frame got %0d starts want 0", fs_count - fs1); else n_pass++;
    n_total++; if (rx_q.size() != 0) $display("FAIL clr_no_rx got %0d frames want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_reset_gap;
    bit got;
    int fs0, t_wr;
    frame_t f;
    logic [W-1:0] e;
    fs0 = fs_count;
    d_valid = 1'b1; d_data = 40'h0F0F0F0F0F;
    @(negedge clk);
    d_data = 40'hF0F0F0F0F0;
    @(negedge clk);
    d_valid = 1'b0;
    wait_fs(fs0, got);
    n_total++; if (!got) $display("FAIL rgap_start got no frame_start want one"); else n_pass++;
    while (got && cyc < last_fs_t + 165) @(negedge clk);
    n_total++; if (d_busy !== 1'b1 || d_level !== 3'd1) $display("FAIL rgap_pre busy=%b level=%0d want 1/1", d_busy, d_level); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (d_busy !== 1'b0) $display("FAIL rgap_busy got %b want 0", d_busy); else n_pass++;
    n_total++; if (d_level !== 3'd0 || d_ready !== 1'b1) $display("FAIL rgap_fifo level=%0d ready=%b want 0/1", d_level, d_ready); else n_pass++;
    n_total++; if (d_sout !== 1'b0 || d_fs !== 1'b0) $display("FAIL rgap_out sout=%b fs=%b want 0/0", d_sout, d_fs); else n_pass++;
    #1 reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    @(negedge clk);
    t_wr = cyc;
    d_valid = 1'b1; d_data = 40'h5A5A5A5A5A; exp_q.push_back(40'h5A5A5A5A5A);
    @(negedge clk);
    d_valid = 1'b0;
    wait_rx(1, 400, got);
    n_total++; if (!got) $display("FAIL rgap_timeout got 0 frames want 1"); else n_pass++;
    if (got) begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      n_total++; if (f.data !== e || !f.ok) $display("FAIL rgap_data got %h ok=%b want %h ok=1", f.data, f.ok, e); else n_pass++;
      n_total++; if (f.t != t_wr + 2) $display("FAIL rgap_latency got %0d want %0d", f.t, t_wr + 2); else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_lsb_small();
    test_push_pop();
    test_overflow();
    test_clear();
    test_reset_gap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
